// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/operand/result bundle for the bit-serial adder
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             busy;
    logic             done;

    modport master (
        output start, input1, input2,
        input  sum, carry, busy, done
    );

    modport slave (
        input  start, input1, input2,
        output sum, carry, busy, done
    );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder built from two half adders and a carry flop
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    serial_adder_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] ps_q, ps_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cflop_q, cflop_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Half adder primitive: returns {carry, sum}
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    logic [1:0]       ha0, ha1;
    logic             sum_bit;
    logic             carry_next;
    logic [WIDTH-1:0] ps_next;

    // Full adder slice for the current LSB pair
    always_comb begin
        ha0        = half_add(a_q[0], b_q[0]);
        ha1        = half_add(ha0[0], cflop_q);
        sum_bit    = ha1[0];
        carry_next = ha0[1] | ha1[1];
        ps_next    = {sum_bit, ps_q[WIDTH-1:1]};
    end

    // Next-state and datapath update; results only move on the last shift
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ps_d    = ps_q;
        cflop_d = cflop_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    a_d     = bus.input1;
                    b_d     = bus.input2;
                    ps_d    = '0;
                    cflop_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                ps_d    = ps_next;
                cflop_d = carry_next;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    sum_d   = ps_next;
                    carry_d = carry_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ps_q    <= '0;
            cflop_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ps_q    <= ps_d;
            cflop_q <= cflop_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign bus.sum   = sum_q;
    assign bus.carry = carry_q;
    assign bus.busy  = (state_q == SHIFT);
    assign bus.done  = (state_q == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;
    localparam int W = 8;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic [7:0] s, input logic c);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(s));
        chk({tag, "_carry"}, 32'(bus.carry), 32'(c));
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
    endtask

    // One pulsed addition with cycle-exact busy/done checks
    task automatic do_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] es, input logic ec, input logic [7:0] prev_s);
        bus.input1 = a;
        bus.input2 = b;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        chk({tag, "_busy0"}, 32'(bus.busy), 32'd1);
        for (int j = 1; j < 8; j++) begin
            tick();
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            chk({tag, "_nodone"}, 32'(bus.done), 32'd0);
            chk({tag, "_hold"}, 32'(bus.sum), 32'(prev_s));
        end
        tick();
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_busyoff"}, 32'(bus.busy), 32'd0);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
        chk({tag, "_carry"}, 32'(bus.carry), 32'(ec));
        tick();
        check_idle({tag, "_after"}, es, ec);
    endtask

    logic [7:0] bb_a [4];
    logic [7:0] bb_b [4];
    logic [7:0] bb_s [4];
    logic       bb_c [4];
    logic [7:0] prev;

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.input1 = '0;
        bus.input2 = '0;

        // Reset held for three cycles
        #1;
        check_idle("rst_t0", 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("rst_hold", 8'h00, 1'b0);
        end
        #2;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_idle("idle", 8'h00, 1'b0);
        end

        // Basic and carry-chain additions
        do_add("add_0f_01", 8'h0F, 8'h01, 8'h10, 1'b0, 8'h00);
        do_add("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1, 8'h10);
        do_add("add_a5_5a", 8'hA5, 8'h5A, 8'hFF, 1'b0, 8'h00);
        do_add("add_ff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1, 8'hFF);

        // Start re-pulsed while busy must be ignored
        bus.input1 = 8'h03;
        bus.input2 = 8'h04;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        tick();
        tick();
        bus.input1 = 8'hFF;
        bus.input2 = 8'hFF;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        chk("busy_restart_busy", 32'(bus.busy), 32'd1);
        for (int j = 4; j < 8; j++) begin
            tick();
            chk("busy_restart_nodone", 32'(bus.done), 32'd0);
        end
        tick();
        chk("busy_restart_done", 32'(bus.done), 32'd1);
        chk("busy_restart_sum", 32'(bus.sum), 32'h07);
        chk("busy_restart_carry", 32'(bus.carry), 32'd0);
        tick();
        chk("busy_restart_idle", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of an operation
        bus.input1 = 8'h80;
        bus.input2 = 8'h80;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        for (int j = 1; j <= 4; j++) tick();
        chk("mid_busy_pre", 32'(bus.busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_idle("mid_rst", 8'h00, 1'b0);
        tick();
        #2;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_idle("mid_nodone", 8'h00, 1'b0);
        end
        do_add("post_rst", 8'h01, 8'h01, 8'h02, 1'b0, 8'h00);

        // Back-to-back with start held; done every 9 cycles
        bb_a[0] = 8'h12; bb_b[0] = 8'h34; bb_s[0] = 8'h46; bb_c[0] = 1'b0;
        bb_a[1] = 8'h80; bb_b[1] = 8'h80; bb_s[1] = 8'h00; bb_c[1] = 1'b1;
        bb_a[2] = 8'h7F; bb_b[2] = 8'h01; bb_s[2] = 8'h80; bb_c[2] = 1'b0;
        bb_a[3] = 8'hC3; bb_b[3] = 8'h5E; bb_s[3] = 8'h21; bb_c[3] = 1'b1;
        prev = 8'h02;
        bus.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.input1 = bb_a[i];
            bus.input2 = bb_b[i];
            for (int j = 1; j <= 8; j++) begin
                tick();
                chk("b2b_nodone", 32'(bus.done), 32'd0);
                chk("b2b_hold", 32'(bus.sum), 32'(prev));
            end
            tick();
            chk("b2b_done", 32'(bus.done), 32'd1);
            chk("b2b_sum", 32'(bus.sum), 32'(bb_s[i]));
            chk("b2b_carry", 32'(bus.carry), 32'(bb_c[i]));
            prev = bb_s[i];
        end
        bus.start = 1'b0;
        tick();
        check_idle("b2b_end", 8'h21, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
